// File: rtl/pim_ctrl_pkg.sv
// Shared definitions for the memory_pim controller.
//   - op encoding for host commands
//   - controller FSM state enum
//   - default memory_pim widths
package pim_ctrl_pkg;

    localparam int unsigned PIM_DATA_W = 40;
    localparam int unsigned PIM_ADDR_W = 9;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } pim_op_e;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWrite   = 2'd1,
        StRdIssue = 2'd2,
        StRdDrain = 2'd3
    } pim_state_e;

endpackage

// File: rtl/pim_rsp_fifo.sv
// Synchronous response FIFO of {last, data} words.
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_push_data write one entry (caller guarantees space)
//   i_pop              remove head entry (caller guarantees non-empty)
//   o_valid            FIFO non-empty
//   o_data             head entry, zero while empty
//   o_count            occupancy, used by the issue credit logic
module pim_rsp_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    assign o_valid = (r_count != '0);
    // Stale storage is masked so an empty FIFO always presents zero.
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/pim_mem_ctrl.sv
// Host-side initiator for one memory_pim block.
// Host commands (valid/ready): single-word writes and burst reads of N one-bit
// results from consecutive addresses. Returned bits are packed LSB-first into
// PACK_W-bit words and queued in a RSP_DEPTH-entry FIFO toward the host.
// Ports:
//   i_clk, i_reset                         clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready                command handshake
//   i_cmd_op, i_cmd_addr, i_cmd_data, i_cmd_len   command fields
//   o_mem_data, o_mem_addr, o_mem_we, i_mem_out   memory_pim interface
//   o_rsp_valid/i_rsp_ready, o_rsp_data, o_rsp_last  response channel
// Optional: define PIM_MEM_CTRL_STATS_EN to add o_stat_writes/o_stat_rd_bits
// saturating counters.
module pim_mem_ctrl
    import pim_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W    = PIM_DATA_W,
    parameter int unsigned ADDR_W    = PIM_ADDR_W,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned PACK_W    = 32,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_op,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_data,
    input  logic [ADDR_W:0]   i_cmd_len,
    output logic [DATA_W-1:0] o_mem_data,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    input  logic              i_mem_out,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [PACK_W-1:0] o_rsp_data,
    output logic              o_rsp_last
`ifdef PIM_MEM_CTRL_STATS_EN
    ,
    output logic [15:0]       o_stat_writes,
    output logic [15:0]       o_stat_rd_bits
`endif
);

    localparam int unsigned PW = $clog2(PACK_W);
    localparam int unsigned CW = $clog2(RSP_DEPTH) + 1;
    localparam int unsigned SW = CW + 1;
    localparam int unsigned LW = ADDR_W + 1;

    pim_state_e        r_state, w_state_d;
    logic              r_cmd_ready, w_cmd_ready_d;
    logic              r_mem_we, w_mem_we_d;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_d;
    logic [DATA_W-1:0] r_mem_data, w_mem_data_d;
    logic [ADDR_W-1:0] r_next_addr, w_next_addr_d;
    logic [LW-1:0]     r_iss_left, w_iss_left_d;
    logic [PW-1:0]     r_iss_pos, w_iss_pos_d;
    logic              r_issue, w_issue_d;     // o_mem_addr holds a freshly issued address
    logic [RD_LAT-1:0] r_pipe, w_pipe_d;       // tag travels alongside the memory latency
    logic [LW-1:0]     r_cap_left, w_cap_left_d;
    logic [PW-1:0]     r_cap_pos, w_cap_pos_d;
    logic [PACK_W-1:0] r_word, w_word_d;
    logic [CW-1:0]     r_open, w_open_d;       // words reserved but not yet in the FIFO

    logic              w_credit, w_first_iss, w_do_issue;
    logic              w_cap, w_cap_final, w_push;
    logic [PACK_W-1:0] w_cap_word;
    logic              w_fifo_valid;
    logic [PACK_W:0]   w_fifo_rdata;
    logic [CW-1:0]     w_fifo_count;

    // A new word may only start if the FIFO is guaranteed room for it.
    assign w_credit    = (SW'(w_fifo_count) + SW'(r_open)) < SW'(RSP_DEPTH);
    assign w_first_iss = (r_iss_pos == '0);
    assign w_do_issue  = (r_state == StRdIssue) && (!w_first_iss || w_credit);

    assign w_cap       = r_pipe[RD_LAT-1];
    assign w_cap_word  = r_word | (PACK_W'(i_mem_out) << r_cap_pos);
    assign w_cap_final = (r_cap_left == LW'(1));
    assign w_push      = w_cap && (w_cap_final || (r_cap_pos == PW'(PACK_W - 1)));

    always_comb begin
        w_state_d     = r_state;
        w_mem_we_d    = 1'b0;
        w_mem_addr_d  = r_mem_addr;
        w_mem_data_d  = r_mem_data;
        w_next_addr_d = r_next_addr;
        w_iss_left_d  = r_iss_left;
        w_iss_pos_d   = r_iss_pos;
        w_issue_d     = 1'b0;
        w_cap_left_d  = r_cap_left;
        w_cap_pos_d   = r_cap_pos;
        w_word_d      = r_word;
        w_open_d      = r_open + CW'(w_do_issue && w_first_iss) - CW'(w_push);

        w_pipe_d[0] = r_issue;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            w_pipe_d[i] = r_pipe[i-1];
        end

        if (w_cap) begin
            w_cap_left_d = r_cap_left - LW'(1);
            if (w_push) begin
                w_word_d    = '0;
                w_cap_pos_d = '0;
            end else begin
                w_word_d    = w_cap_word;
                w_cap_pos_d = r_cap_pos + PW'(1);
            end
        end

        case (r_state)
            StIdle: begin
                if (i_cmd_valid && r_cmd_ready) begin
                    if (i_cmd_op == OP_WRITE) begin
                        w_state_d    = StWrite;
                        w_mem_we_d   = 1'b1;
                        w_mem_addr_d = i_cmd_addr;
                        w_mem_data_d = i_cmd_data;
                    end else if (i_cmd_len != '0) begin
                        w_state_d     = StRdIssue;
                        w_next_addr_d = i_cmd_addr;
                        w_iss_left_d  = i_cmd_len;
                        w_iss_pos_d   = '0;
                        w_cap_left_d  = i_cmd_len;
                        w_cap_pos_d   = '0;
                        w_word_d      = '0;
                    end
                end
            end
            StWrite: begin
                w_state_d = StIdle;
            end
            StRdIssue: begin
                if (w_do_issue) begin
                    w_mem_addr_d  = r_next_addr;
                    w_next_addr_d = r_next_addr + ADDR_W'(1);
                    w_issue_d     = 1'b1;
                    w_iss_left_d  = r_iss_left - LW'(1);
                    w_iss_pos_d   = (r_iss_pos == PW'(PACK_W - 1)) ? '0 : r_iss_pos + PW'(1);
                    if (r_iss_left == LW'(1)) begin
                        w_state_d = StRdDrain;
                    end
                end
            end
            StRdDrain: begin
                // Final bit captured implies its word was pushed and the pipe is empty.
                if (r_cap_left == '0) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        w_cmd_ready_d = (w_state_d == StIdle);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_cmd_ready <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_next_addr <= '0;
            r_iss_left  <= '0;
            r_iss_pos   <= '0;
            r_issue     <= 1'b0;
            r_pipe      <= '0;
            r_cap_left  <= '0;
            r_cap_pos   <= '0;
            r_word      <= '0;
            r_open      <= '0;
        end else begin
            r_state     <= w_state_d;
            r_cmd_ready <= w_cmd_ready_d;
            r_mem_we    <= w_mem_we_d;
            r_mem_addr  <= w_mem_addr_d;
            r_mem_data  <= w_mem_data_d;
            r_next_addr <= w_next_addr_d;
            r_iss_left  <= w_iss_left_d;
            r_iss_pos   <= w_iss_pos_d;
            r_issue     <= w_issue_d;
            r_pipe      <= w_pipe_d;
            r_cap_left  <= w_cap_left_d;
            r_cap_pos   <= w_cap_pos_d;
            r_word      <= w_word_d;
            r_open      <= w_open_d;
        end
    end

    pim_rsp_fifo #(
        .WIDTH (PACK_W + 1),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (w_push),
        .i_push_data ({w_cap_final, w_cap_word}),
        .i_pop       (w_fifo_valid && i_rsp_ready),
        .o_valid     (w_fifo_valid),
        .o_data      (w_fifo_rdata),
        .o_count     (w_fifo_count)
    );

    assign o_cmd_ready = r_cmd_ready;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_data  = r_mem_data;
    assign o_rsp_valid = w_fifo_valid;
    assign o_rsp_data  = w_fifo_rdata[PACK_W-1:0];
    assign o_rsp_last  = w_fifo_rdata[PACK_W];

`ifdef PIM_MEM_CTRL_STATS_EN
    logic [15:0] r_stat_writes;
    logic [15:0] r_stat_rd_bits;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stat_writes  <= '0;
            r_stat_rd_bits <= '0;
        end else begin
            if ((r_state == StWrite) && (r_stat_writes != 16'hFFFF)) begin
                r_stat_writes <= r_stat_writes + 16'd1;
            end
            if (w_cap && (r_stat_rd_bits != 16'hFFFF)) begin
                r_stat_rd_bits <= r_stat_rd_bits + 16'd1;
            end
        end
    end

    assign o_stat_writes  = r_stat_writes;
    assign o_stat_rd_bits = r_stat_rd_bits;
`endif

endmodule

// File: tb/tb_pim_mem_ctrl.sv
// Self-checking bench for pim_mem_ctrl with a one-bit-per-address memory model.
module tb_pim_mem_ctrl;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [8:0]  cmd_addr;
    logic [39:0] cmd_data;
    logic [9:0]  cmd_len;
    logic [39:0] mem_data;
    logic [8:0]  mem_addr;
    logic        mem_we;
    logic        mem_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_last;

    int n_cmp = 0;
    int n_err = 0;

    bit          bits [512];
    logic [32:0] exp_q [$];

    pim_mem_ctrl dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_addr  (cmd_addr),
        .i_cmd_data  (cmd_data),
        .i_cmd_len   (cmd_len),
        .o_mem_data  (mem_data),
        .o_mem_addr  (mem_addr),
        .o_mem_we    (mem_we),
        .i_mem_out   (mem_out),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_last  (rsp_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered read port, one cycle latency.
    always @(posedge clk) mem_out <= bits[mem_addr];

    task automatic fill_bits(input bit alt);
        for (int a = 0; a < 512; a++) begin
            bits[a] = alt ? a[0] : 1'($urandom);
        end
    endtask

    // Expected response words of a burst, straight from the packing rules.
    task automatic model_burst(input int start, input int len);
        int nw;
        logic [32:0] e;
        nw = (len + 31) / 32;
        for (int w = 0; w < nw; w++) begin
            e = '0;
            for (int b = 0; b < 32; b++) begin
                if (w * 32 + b < len) e[b] = bits[(start + w * 32 + b) % 512];
            end
            e[32] = (w == nw - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_cmd(input logic op, input logic [8:0] addr, input logic [39:0] data,
                            input logic [9:0] len, input string name);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_len   = len;
        while (cmd_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s accept: cmd_ready=%b, expected 1 within 2000 cycles", name, cmd_ready);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic collect(input int prob, input string name);
        int budget;
        int idx;
        logic [32:0] e;
        budget = 0;
        idx = 0;
        while (exp_q.size() > 0 && budget < 20000) begin
            @(negedge clk);
            budget++;
            rsp_ready = ($urandom_range(0, 99) < prob);
            if (rsp_valid === 1'b1 && rsp_ready) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({rsp_last, rsp_data} !== e) begin
                    n_err++;
                    $display("FAIL %s word %0d: got last=%b data=%h, expected last=%b data=%h",
                             name, idx, rsp_last, rsp_data, e[32], e[31:0]);
                end
                idx++;
            end
        end
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s timeout: %0d words missing, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        rsp_ready = 1'b1;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s extra word: rsp_valid=%b data=%h, expected rsp_valid=0",
                     name, rsp_valid, rsp_data);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({mem_we, mem_addr, mem_data, rsp_valid, rsp_data, rsp_last, cmd_ready} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: we=%b addr=%h data=%h rv=%b rd=%h rl=%b rdy=%b, expected all 0",
                     mem_we, mem_addr, mem_data, rsp_valid, rsp_data, rsp_last, cmd_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: cmd_ready=%b, expected 1", cmd_ready);
        end
    endtask

    task automatic check_write(input logic [8:0] a, input logic [39:0] d, input string name);
        send_cmd(1'b0, a, d, 10'd0, name);
        n_cmp++;
        if ({mem_we, mem_addr, mem_data} !== {1'b1, a, d}) begin
            n_err++;
            $display("FAIL %s cycle: we=%b addr=%h data=%h, expected we=1 addr=%h data=%h",
                     name, mem_we, mem_addr, mem_data, a, d);
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (mem_we !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s after: we=%b rdy=%b, expected we=0 rdy=1", name, mem_we, cmd_ready);
        end
    endtask

    task automatic test_write();
        logic [39:0] d;
        check_write(9'h005, 40'hAB_CDEF_0123, "write_fixed");
        for (int i = 0; i < 3; i++) begin
            d[31:0]  = $urandom;
            d[39:32] = 8'($urandom);
            check_write(9'($urandom), d, "write_rand");
        end
    endtask

    task automatic test_read_basic();
        fill_bits(1'b1);
        model_burst(9'h010, 8);
        send_cmd(1'b1, 9'h010, '0, 10'd8, "read8");
        collect(100, "read8");
        fill_bits(1'b0);
        for (int i = 0; i < 4; i++) begin
            int s;
            int l;
            s = $urandom_range(0, 511);
            l = $urandom_range(1, 100);
            model_burst(s, l);
            send_cmd(1'b1, 9'(s), '0, 10'(l), "read_rand");
            collect($urandom_range(40, 100), "read_rand");
        end
    endtask

    task automatic test_wrap512();
        fill_bits(1'b0);
        model_burst(9'h1F0, 512);
        send_cmd(1'b1, 9'h1F0, '0, 10'd512, "read512");
        collect(70, "read512");
    endtask

    task automatic test_back_pressure();
        logic [8:0] s;
        logic [8:0] a;
        fill_bits(1'b0);
        s = 9'($urandom);
        model_burst(s, 192);
        rsp_ready = 1'b0;
        send_cmd(1'b1, s, '0, 10'd192, "stall");
        repeat (250) @(negedge clk);
        n_cmp++;
        if (mem_addr !== s + 9'd127 || rsp_valid !== 1'b1) begin
            n_err++;
            $display("FAIL stall_point: addr=%h rv=%b, expected addr=%h rv=1",
                     mem_addr, rsp_valid, s + 9'd127);
        end
        a = mem_addr;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (mem_addr !== a) begin
            n_err++;
            $display("FAIL stall_hold: addr=%h, expected %h", mem_addr, a);
        end
        collect(100, "stall");
    endtask

    task automatic test_len0_and_33();
        logic [8:0] a;
        bit seen;
        fill_bits(1'b0);
        a = mem_addr;
        seen = 1'b0;
        send_cmd(1'b1, 9'h0AA, '0, 10'd0, "len0");
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || mem_addr !== a) seen = 1'b1;
        end
        n_cmp++;
        if (seen || cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL len0: activity=%b rdy=%b, expected activity=0 rdy=1", seen, cmd_ready);
        end
        model_burst(0, 33);
        send_cmd(1'b1, 9'h000, '0, 10'd33, "len33");
        collect(100, "len33");
    endtask

    task automatic test_back_to_back();
        int s1;
        int s2;
        fill_bits(1'b0);
        s1 = $urandom_range(0, 511);
        s2 = $urandom_range(0, 511);
        rsp_ready = 1'b0;
        model_burst(s1, 40);
        model_burst(s2, 20);
        send_cmd(1'b1, 9'(s1), '0, 10'd40, "b2b_a");
        send_cmd(1'b1, 9'(s2), '0, 10'd20, "b2b_b");
        collect(60, "b2b");
    endtask

    task automatic test_reset_mid();
        int s;
        fill_bits(1'b0);
        rsp_ready = 1'b0;
        send_cmd(1'b1, 9'h100, '0, 10'd40, "rst_pre");
        s = $urandom_range(0, 511);
        send_cmd(1'b1, 9'(s), '0, 10'd64, "rst_mid");
        repeat (22) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 9'h000 || cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_flush: rv=%b we=%b addr=%h rdy=%b, expected 0 0 000 0",
                     rsp_valid, mem_we, mem_addr, cmd_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_ready: rdy=%b rv=%b, expected rdy=1 rv=0", cmd_ready, rsp_valid);
        end
        s = $urandom_range(0, 511);
        model_burst(s, 1);
        send_cmd(1'b1, 9'(s), '0, 10'd1, "rst_len1");
        collect(100, "rst_len1");
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        cmd_len   = '0;
        rsp_ready = 1'b0;
        fill_bits(1'b1);
        test_reset();
        test_write();
        test_read_basic();
        test_wrap512();
        test_back_pressure();
        test_len0_and_33();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
